// File: rtl/band_doa_packer.sv
// Packs per-band dominant eigenvector results into framed stream words.
// Two banks ping-pong: one captures bands while the other is serialized out.
module band_doa_packer #(
  parameter int DIN_WIDTH = 32,
  parameter int BANDS     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH-1:0] lamb1,
  input  logic signed [DIN_WIDTH-1:0] lamb2,
  input  logic signed [DIN_WIDTH-1:0] eigen1_y,
  input  logic signed [DIN_WIDTH-1:0] eigen2_y,
  input  logic signed [DIN_WIDTH-1:0] eigen_x,
  input  logic                        din_valid,
  input  logic                        din_error,
  input  logic [((BANDS > 1) ? $clog2(BANDS) : 1)-1:0] band_in,
  output logic [DIN_WIDTH-1:0]        dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic                        overrun
);

  localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   band_cnt, band_cnt_next;
  logic [1:0]      field_cnt, field_cnt_next;
  logic            start_q, start_next;
  logic            cap_sel;
  logic [BANDS-1:0] mask [2];
  logic [15:0]     frame_cnt;

  logic [DIN_WIDTH-1:0] y_mem [2][BANDS];
  logic [DIN_WIDTH-1:0] x_mem [2][BANDS];
  logic [DIN_WIDTH-1:0] p_mem [2][BANDS];
  logic [BANDS-1:0]     err_mem [2];

  logic [DIN_WIDTH-1:0] sel_y, sel_p, hdr;
  logic [BANDS-1:0]     band_bit;
  logic send_sel, band_ok, cap_full, free, hs, last_hs;
  logic swap_now, pending, cap_bank, cap_we, drop;

  assign sel_y    = (lamb1 >= lamb2) ? eigen1_y : eigen2_y;
  assign sel_p    = (lamb1 >= lamb2) ? lamb1 : lamb2;
  assign band_ok  = ({1'b0, band_in} < (BW+1)'(BANDS));
  assign band_bit = BANDS'(1) << band_in;
  assign send_sel = ~cap_sel;

  // A full capture mask is a completed frame; it swaps in as soon as the
  // sender is free (idle with nothing launching, or finishing its last word).
  assign cap_full = &mask[cap_sel];
  assign hs       = dout_valid && dout_ready;
  assign last_hs  = hs && dout_last;
  assign free     = (state == IDLE) && !start_q;
  assign swap_now = cap_full && (free || last_hs);
  assign pending  = cap_full && !swap_now;
  assign cap_bank = cap_sel ^ swap_now;
  assign cap_we   = din_valid && !rst && band_ok && !pending;
  assign drop     = din_valid && !rst && pending;

  // NOTE: sample storage has no reset; the masks alone say which entries are live.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      y_mem[cap_bank][band_in]   <= sel_y;
      x_mem[cap_bank][band_in]   <= eigen_x;
      p_mem[cap_bank][band_in]   <= sel_p;
      err_mem[cap_bank][band_in] <= din_error;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      band_cnt  <= '0;
      field_cnt <= '0;
      start_q   <= 1'b0;
      cap_sel   <= 1'b0;
      mask[0]   <= '0;
      mask[1]   <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      band_cnt  <= band_cnt_next;
      field_cnt <= field_cnt_next;
      start_q   <= start_next;
      if (swap_now) begin
        cap_sel        <= ~cap_sel;
        mask[send_sel] <= cap_we ? band_bit : '0;
      end else if (cap_we) begin
        mask[cap_sel] <= mask[cap_sel] | band_bit;
      end
      if (last_hs) frame_cnt <= frame_cnt + 16'd1;
      if (drop)    overrun   <= 1'b1;
    end
  end

  always_comb begin
    hdr = '0;
    hdr[DIN_WIDTH-1 -: 16] = frame_cnt;
    hdr[BANDS-1:0]         = err_mem[send_sel];
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    band_cnt_next  = band_cnt;
    field_cnt_next = field_cnt;
    start_next     = start_q;
    dout_valid     = 1'b0;
    dout_last      = 1'b0;
    dout           = '0;

    if (swap_now && free) start_next = 1'b1;

    case (state)
      IDLE: begin
        if (start_q) begin
          state_next = HEADER;
          start_next = 1'b0;
        end
      end
      HEADER: begin
        dout_valid = 1'b1;
        dout       = hdr;
        if (hs) begin
          state_next     = PAYLOAD;
          band_cnt_next  = '0;
          field_cnt_next = '0;
        end
      end
      PAYLOAD: begin
        dout_valid = 1'b1;
        dout_last  = (band_cnt == BW'(BANDS - 1)) && (field_cnt == 2'd2);
        case (field_cnt)
          2'd0:    dout = y_mem[send_sel][band_cnt];
          2'd1:    dout = x_mem[send_sel][band_cnt];
          default: dout = p_mem[send_sel][band_cnt];
        endcase
        if (hs) begin
          if (dout_last) begin
            // A pending frame swaps in on this same edge, keeping the stream gapless.
            state_next = swap_now ? HEADER : IDLE;
          end else if (field_cnt == 2'd2) begin
            field_cnt_next = '0;
            band_cnt_next  = band_cnt + BW'(1);
          end else begin
            field_cnt_next = field_cnt + 2'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_band_doa_packer.sv
// Randomized bench for band_doa_packer against a frame-level reference model.
module tb_band_doa_packer;

  localparam int DW  = 32;
  localparam int NB  = 4;
  localparam int WPF = 1 + 3 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [DW-1:0] lamb1 = '0, lamb2 = '0, eigen1_y = '0, eigen2_y = '0, eigen_x = '0;
  logic din_valid = 1'b0, din_error = 1'b0;
  logic [1:0] band_in = '0;
  logic [DW-1:0] dout;
  logic dout_valid, dout_last, overrun;
  logic dout_ready = 1'b0;

  band_doa_packer #(.DIN_WIDTH(DW), .BANDS(NB)) dut (
    .clk(clk), .rst(rst), .lamb1(lamb1), .lamb2(lamb2), .eigen1_y(eigen1_y),
    .eigen2_y(eigen2_y), .eigen_x(eigen_x), .din_valid(din_valid), .din_error(din_error),
    .band_in(band_in), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-band latest values; a full set emits a whole frame.
  logic [DW-1:0] m_y [NB], m_x [NB], m_p [NB];
  logic [NB-1:0] m_err = '0, m_mask = '0;
  logic [15:0]   m_cnt = '0;
  logic [DW-1:0] exp_q [$];
  bit            exp_last_q [$];
  int outstanding = 0;
  int hs_total = 0;
  bit mon_en = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    exp_last_q.delete();
    m_mask = '0;
    m_cnt = '0;
    outstanding = 0;
  endtask

  task automatic model_sample(input int b, input logic signed [DW-1:0] l1, l2, y1, y2, x,
                              input bit e);
    logic [DW-1:0] hdr;
    if (l1 >= l2) begin m_y[b] = y1; m_p[b] = l1; end
    else          begin m_y[b] = y2; m_p[b] = l2; end
    m_x[b] = x;
    m_err[b] = e;
    m_mask[b] = 1'b1;
    if (&m_mask) begin
      hdr = '0;
      hdr[DW-1 -: 16] = m_cnt;
      hdr[NB-1:0] = m_err;
      exp_q.push_back(hdr); exp_last_q.push_back(1'b0);
      for (int i = 0; i < NB; i++) begin
        exp_q.push_back(m_y[i]); exp_last_q.push_back(1'b0);
        exp_q.push_back(m_x[i]); exp_last_q.push_back(1'b0);
        exp_q.push_back(m_p[i]); exp_last_q.push_back(i == NB - 1);
      end
      m_cnt = m_cnt + 16'd1;
      m_mask = '0;
      outstanding++;
    end
  endtask

  // Monitor: every presented word must equal the head of the expected stream.
  always @(negedge clk) begin
    if (mon_en && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(dout_valid), 64'd0);
      end else begin
        check("dout", 64'(dout), 64'(exp_q[0]));
        check("dout_last", 64'(dout_last), 64'(exp_last_q[0]));
        if (dout_ready) begin
          if (exp_last_q[0]) outstanding--;
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          hs_total++;
        end
      end
    end
  end

  // Ready pattern: 0 always, 1 toggles 1,0,0,1, 2 random, 3 held low.
  int rmode = 0;
  int rphase = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: dout_ready = 1'b1;
      1: begin
        dout_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
        rphase++;
      end
      2: dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int b, input logic signed [DW-1:0] l1, l2, y1, y2, x,
                       input bit e, input bit apply);
    band_in = 2'(b); lamb1 = l1; lamb2 = l2; eigen1_y = y1; eigen2_y = y2; eigen_x = x;
    din_error = e; din_valid = 1'b1;
    @(posedge clk);
    if (apply) model_sample(b, l1, l2, y1, y2, x, e);
    #1 din_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    din_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_frame(input bit apply);
    bit [NB-1:0] seen = '0;
    logic signed [DW-1:0] l1, l2;
    int b;
    while (!(&seen)) begin
      b = $urandom_range(0, NB - 1);
      l1 = $urandom;
      l2 = ($urandom_range(0, 7) == 0) ? l1 : $urandom;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive(b, l1, l2, $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0), apply);
      seen[b] = 1'b1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    do_reset();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_last", 64'(dout_last), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // A sample presented during reset must not count toward the frame.
    rst = 1'b1; band_in = 2'd0; din_valid = 1'b1; eigen1_y = 32'hDEAD; lamb1 = 9; lamb2 = 1;
    @(posedge clk); #1 rst = 1'b0; din_valid = 1'b0;
    for (int b = 1; b < NB; b++) drive(b, 5, 3, 32'h100, 32'h999, 32'h200, 1'b0, 1'b1);
    idle(4);
    check("rst_drops_din", 64'(dout_valid), 64'd0);
    drive(0, 5, 3, 32'h100, 32'h999, 32'h200, 1'b0, 1'b1);
    check("lat_e0", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_e1", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_e2", 64'(dout_valid), 64'd1);
    check("lat_hdr", 64'(dout), 64'h0);
    wait_drain("single_drain", 100);

    // Dominant selection by signed compare plus error mask.
    drive(0, 1, 2, 32'h11, 32'h12, 32'h13, 1'b0, 1'b1);
    drive(2, -4, 7, 32'h22, 32'h33, 32'h44, 1'b1, 1'b1);
    drive(1, -1, -1, 32'h55, 32'h56, 32'h57, 1'b0, 1'b1);
    drive(3, 32'sh7FFF_FFFF, 32'sh8000_0000, 32'h66, 32'h67, 32'h68, 1'b0, 1'b1);
    wait_drain("select_drain", 100);

    // Backpressure pattern.
    rmode = 1;
    base = hs_total;
    rand_frame(1'b1);
    wait_drain("bp_drain", 200);
    check("bp_handshakes", 64'(hs_total - base), 64'(WPF));

    // Out-of-order with a duplicate band.
    rmode = 0;
    drive(3, 2, 1, 32'h31, 32'h32, 32'h33, 1'b0, 1'b1);
    drive(1, 2, 1, 32'h11, 32'h12, 32'h13, 1'b0, 1'b1);
    drive(1, 2, 1, 32'h77, 32'h78, 32'h79, 1'b0, 1'b1);
    drive(0, 2, 1, 32'h01, 32'h02, 32'h03, 1'b0, 1'b1);
    drive(2, 2, 1, 32'h21, 32'h22, 32'h23, 1'b0, 1'b1);
    wait_drain("ooo_drain", 100);
    idle(3);
    check("ooo_single_frame", 64'(dout_valid), 64'd0);

    // Overrun: one frame sending, one pending, the third dropped.
    do_reset();
    rmode = 3;
    rand_frame(1'b1);
    rand_frame(1'b1);
    idle(2);
    check("ovr_before", 64'(overrun), 64'd0);
    rand_frame(1'b0);
    idle(1);
    check("ovr_set", 64'(overrun), 64'd1);
    @(posedge clk);
    rmode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("b2b_cycles", 64'(n), 64'(2 * WPF));
    #1;
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Reset while word 5 is on the bus.
    do_reset();
    check("rst_clears_ovr", 64'(overrun), 64'd0);
    rand_frame(1'b1);
    base = hs_total;
    n = 0;
    while ((hs_total - base) < 4 && n < 100) begin @(posedge clk); #1; n++; end
    check("mid_reached_w5", 64'(hs_total - base), 64'd4);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_valid_low", 64'(dout_valid), 64'd0);
    model_reset();
    mon_en = 1'b1;
    idle(3);
    check("mid_no_resume", 64'(dout_valid), 64'd0);
    rand_frame(1'b1);
    wait_drain("mid_drain", 100);

    // Random traffic, never more than one frame sending plus one pending.
    for (int f = 0; f < 30; f++) begin
      n = 0;
      while (outstanding > 1 && n < 500) begin @(posedge clk); #1; n++; end
      check("room", 64'(outstanding <= 1), 64'd1);
      rmode = $urandom_range(0, 2);
      idle($urandom_range(0, 3));
      rand_frame(1'b1);
    end
    rmode = 0;
    wait_drain("final_drain", 2000);
    idle(3);
    check("final_outstanding", 64'(outstanding), 64'd0);
    check("final_no_overrun", 64'(overrun), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/band_doa_packer.md
BAND_DOA_PACKER -- requirements
Module: band_doa_packer

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32: width of the signed eigen inputs; also the width of dout.
REQ-002 SHALL have parameter BANDS, default 4: number of bands per frame; DIN_WIDTH SHALL be at least 16+BANDS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports lamb1, lamb2, input, DIN_WIDTH each, signed: the two eigenvalues of one band.
REQ-006 SHALL have ports eigen1_y, eigen2_y, eigen_x, input, DIN_WIDTH each, signed: the eigenvector components.
REQ-007 SHALL have port din_valid, input, 1 bit: the eigen inputs, din_error and band_in are valid this cycle.
REQ-008 SHALL have port din_error, input, 1 bit: the linear-algebra stage flagged this band's result.
REQ-009 SHALL have port band_in, input, $clog2(BANDS) bits: band index of the current result.
REQ-010 SHALL have port dout, output, DIN_WIDTH bits: stream data word.
REQ-011 SHALL have port dout_valid, output, 1 bit: stream valid.
REQ-012 SHALL have port dout_ready, input, 1 bit: stream ready from downstream.
REQ-013 SHALL have port dout_last, output, 1 bit: marks the final word of a frame.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a frame is dropped.

Function
REQ-015 On each din_valid, SHALL select the dominant eigenvector: if lamb1>=lamb2 (signed compare), Y=eigen1_y and P=lamb1; otherwise Y=eigen2_y and P=lamb2. X=eigen_x in both cases.
REQ-016 SHALL hold two banks, each storing {Y,X,P,err} per band plus a BANDS-bit received mask; one bank captures while the other sends.
REQ-017 A capture write SHALL store into the entry at band_in and set that band's mask bit. A repeated band before the frame completes SHALL overwrite the entry (latest wins). When BANDS is not a power of 2, band_in>=BANDS SHALL be ignored.
REQ-018 The frame SHALL be complete when the capture mask is all ones. If the sender is idle, the banks SHALL swap, the new capture bank's mask SHALL clear, and the sender SHALL start.
REQ-019 If the sender is busy at completion, the frame SHALL be marked pending. While a frame is pending, din_valid samples SHALL be dropped and overrun SHALL be set.
REQ-020 Sender FSM states: IDLE, HEADER, PAYLOAD.
- IDLE->HEADER on a completed or pending frame.
- HEADER->PAYLOAD on handshake.
- PAYLOAD->IDLE on the handshake of the last word; if a frame is pending, go to HEADER directly instead, swapping banks in the same cycle.
REQ-021 Frame format: 1+3*BANDS words.
- Header: [31:16] = 16-bit frame counter; [BANDS-1:0] = err mask; other bits 0.
- Then, for band 0..BANDS-1 in order: Y, X, P.
REQ-022 Handshake: a word transfers when dout_valid and dout_ready are both high. While dout_valid=1 and dout_ready=0, dout and dout_last SHALL hold stable. dout_valid SHALL NOT depend combinationally on dout_ready.
REQ-023 dout_last SHALL be 1 only on word 3*BANDS (the final P).
REQ-024 The frame counter SHALL increment on the dout_last handshake and wrap 0xFFFF->0x0000.
REQ-025 Latency: with the sender idle, the header's dout_valid SHALL rise 2 rising edges after the edge that samples the completing din_valid.
REQ-026 With dout_ready held at 1, words SHALL transfer back to back, one per cycle, with no bubbles, including across pending frames.
REQ-027 A din_valid that completes a frame in the same cycle as the sender's final handshake SHALL be treated as a frame completing at idle: the frame is not dropped and overrun is not set.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL clear dout, dout_valid, dout_last, overrun, both masks, the pending flag, the frame counter, and the bank select, and SHALL set the FSM to IDLE.
REQ-029 Reset mid-frame SHALL abandon the transfer: dout_valid is 0 after that edge, and no partial frame resumes.
REQ-030 din_valid SHALL be ignored in any cycle in which rst=1.

Verification
REQ-031 Single frame: BANDS=4, bands 0..3 each with lamb1=5, lamb2=3, eigen1_y=0x100, eigen_x=0x200, dout_ready=1 -> 13 words: header 0x00000000, then (0x100, 0x200, 5) x4; dout_last on word 13; dout_valid rises 2 edges after the band-3 sample.
REQ-032 Selection and error: band 2 with lamb1=-4, lamb2=7, eigen2_y=0x33, din_error=1 -> band 2 Y=0x33, P=7; header low nibble=0x4.
REQ-033 Backpressure: dout_ready toggles 1,0,0,1 repeatedly -> data unchanged while stalled; exactly 13 handshakes; counter increments to 1 after the frame.
REQ-034 Overrun: dout_ready=0, three full frames input -> frame 0 sending, frame 1 pending, frame 2 dropped, overrun=1; after dout_ready=1, frames with counters 0 and 1 emitted back to back.
REQ-035 Out-of-order and duplicates: bands 3,1,1,0,2, with the second band-1 Y=0x77 -> a single frame; band 1 Y=0x77.
REQ-036 Reset mid-frame: rst pulsed during word 5 -> dout_valid=0 next cycle, counter 0; the next full frame header is 0x00000000.
